// File: rtl/sp_adder_arbiter_if.sv
// Requester/adder-facing bus of sp_adder_arbiter.
// slave  : the arbiter side (drives grants, responses and the adder operands).
// master : the environment side (requesters plus the shared adder).
interface sp_adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic                       hold;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*WIDTH-1:0]   req_a;
    logic [NUM_REQ*WIDTH-1:0]   req_b;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [WIDTH-1:0]           resp_sum;
    logic                       busy;
    logic                       add_ce;
    logic [WIDTH-1:0]           add_a;
    logic [WIDTH-1:0]           add_b;
    logic [WIDTH-1:0]           add_s;

    modport slave (
        input  hold, req_valid, req_a, req_b, add_s,
        output req_ready, resp_valid, resp_sum, busy, add_ce, add_a, add_b
    );

    modport master (
        output hold, req_valid, req_a, req_b, add_s,
        input  req_ready, resp_valid, resp_sum, busy, add_ce, add_a, add_b
    );
endinterface

// File: rtl/sp_adder_arbiter.sv
// sp_adder_arbiter: shares one pipelined adder between NUM_REQ requesters.
// One grant per non-hold cycle; the granted operands are registered into the
// adder and a {valid,id} tag follows them down a shadow pipeline of depth
// LATENCY+1 so the sum can be routed back to its requester.
// Build option: define SP_ADDER_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) with no pointer state.
module sp_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sp_adder_arbiter_if.slave    bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    // Requester lanes: lane i sits at bits [i*WIDTH +: WIDTH], which is
    // exactly the packed-array layout.
    logic [NUM_REQ-1:0][WIDTH-1:0] w_a_lane;
    logic [NUM_REQ-1:0][WIDTH-1:0] w_b_lane;
    assign w_a_lane = bus.req_a;
    assign w_b_lane = bus.req_b;

    logic                  w_open;
    logic                  w_lo_vld;
    logic [ID_W-1:0]       w_lo_id;
    logic                  w_found;
    logic [ID_W-1:0]       w_pick;
    logic                  w_accept;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [NUM_REQ-1:0]    w_resp;
    logic                  w_busy;
    tag_t                  w_tail;

    logic [WIDTH-1:0]      r_add_a;
    logic [WIDTH-1:0]      r_add_b;
    tag_t [LATENCY:0]      r_tag;

    // Nothing is granted or returned while in reset or stalled.
    assign w_open = i_rst_n & ~bus.hold;

`ifdef SP_ADDER_ARB_RR_EN
    logic                  w_hi_vld;
    logic [ID_W-1:0]       w_hi_id;
    logic [ID_W-1:0]       r_ptr;

    // Lowest valid index above the pointer (hi) and at/below it (lo);
    // descending scan so the last hit is the lowest index in each half.
    always_comb begin
        w_lo_vld = 1'b0;
        w_lo_id  = '0;
        w_hi_vld = 1'b0;
        w_hi_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (i > int'(r_ptr)) begin
                    w_hi_vld = 1'b1;
                    w_hi_id  = ID_W'(i);
                end else begin
                    w_lo_vld = 1'b1;
                    w_lo_id  = ID_W'(i);
                end
            end
        end
    end

    // Scanning from pointer+1 with wrap: the upper half goes first.
    assign w_pick  = w_hi_vld ? w_hi_id : w_lo_id;
    assign w_found = w_hi_vld | w_lo_vld;

    // Pointer remembers the last winner; reset makes requester 0 first.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_ptr <= w_pick;
        end
    end
`else
    // Fixed priority: lowest valid index wins, no history.
    always_comb begin
        w_lo_vld = 1'b0;
        w_lo_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_lo_vld = 1'b1;
                w_lo_id  = ID_W'(i);
            end
        end
    end

    assign w_pick  = w_lo_id;
    assign w_found = w_lo_vld;
`endif

    assign w_accept = w_open & w_found;

    // One-hot grant decoded from the winner; independent of operand values.
    always_comb begin
        w_gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt[i] = w_accept & (w_pick == ID_W'(i));
        end
    end

    // Operand register feeding the adder; holds its value between accepts.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_add_a <= '0;
            r_add_b <= '0;
        end else if (w_accept) begin
            r_add_a <= w_a_lane[w_pick];
            r_add_b <= w_b_lane[w_pick];
        end
    end

    // Tag shadow pipeline: advances in lock-step with the adder clock-enable.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tag <= '0;
        end else if (!bus.hold) begin
            r_tag[0].vld <= w_accept;
            r_tag[0].id  <= w_pick;
            for (int s = 1; s <= LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_tail = r_tag[LATENCY];

    // Route the tail sum back; masking with hold means a stalled tail is
    // shown once, in the first unheld cycle, just before it shifts out.
    always_comb begin
        w_resp = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_resp[i] = w_tail.vld & w_open & (w_tail.id == ID_W'(i));
        end
    end

    // Busy while any stage carries a live tag.
    always_comb begin
        w_busy = 1'b0;
        for (int s = 0; s <= LATENCY; s++) begin
            w_busy = w_busy | r_tag[s].vld;
        end
    end

    assign bus.req_ready  = w_gnt;
    assign bus.resp_valid = w_resp;
    assign bus.resp_sum   = bus.add_s;
    assign bus.busy       = w_busy;
    assign bus.add_ce     = w_open;
    assign bus.add_a      = r_add_a;
    assign bus.add_b      = r_add_b;
endmodule

// File: tb/tb_sp_adder_arbiter.sv
// Directed bench for sp_adder_arbiter: a LATENCY=1 instance for most steps
// and a LATENCY=4 instance for the deep-pipeline step. The shared adder is
// modelled here as a clock-enabled register chain.
module tb_sp_adder_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sp_adder_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus0 ();
    sp_adder_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus1 ();

    sp_adder_arbiter #(.NUM_REQ(4), .WIDTH(8), .LATENCY(1)) u0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    sp_adder_arbiter #(.NUM_REQ(4), .WIDTH(8), .LATENCY(4)) u1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    // Adder models: LATENCY clock-enabled stages from operand capture to S.
    logic [7:0] s0;
    logic [7:0] s1 [4];
    always @(posedge clk) begin
        if (bus0.add_ce) s0 <= bus0.add_a + bus0.add_b;
    end
    always @(posedge clk) begin
        if (bus1.add_ce) begin
            s1[0] <= bus1.add_a + bus1.add_b;
            s1[1] <= s1[0];
            s1[2] <= s1[1];
            s1[3] <= s1[2];
        end
    end
    assign bus0.add_s = s0;
    assign bus1.add_s = s1[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected winner of the k-th cycle of the all-valid burst.
    function automatic int gexp(input int k);
`ifdef SP_ADDER_ARB_RR_EN
        return k % 4;
`else
        return 0;
`endif
    endfunction

    int stbl [4] = '{32'h06, 32'h27, 32'h48, 32'h69};

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus0.hold = 1'b0; bus0.req_valid = '0; bus0.req_a = '0; bus0.req_b = '0;
        bus1.hold = 1'b0; bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0;

        // Reset
        tick();
        bus0.req_valid = 4'hF;
        #1;
        chk("rst_ready", bus0.req_ready, 0);
        chk("rst_ce", bus0.add_ce, 0);
        tick();
        #1;
        chk("rst_resp", bus0.resp_valid, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_add_a", bus0.add_a, 0);
        chk("rst_add_b", bus0.add_b, 0);
        chk("rst_busy1", bus1.busy, 0);

        // All four requesting for 8 cycles; a[i]=0x20*i+5, b[i]=i+1
        bus0.req_a = {8'h65, 8'h45, 8'h25, 8'h05};
        bus0.req_b = {8'h04, 8'h03, 8'h02, 8'h01};
        for (int k = 0; k < 10; k++) begin
            tick();
            rst_n = 1'b1;
            bus0.req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) chk("burst_gnt", bus0.req_ready, 32'd1 << gexp(k));
            if (k >= 2) begin
                chk("burst_resp", bus0.resp_valid, 32'd1 << gexp(k - 2));
                chk("burst_sum", bus0.resp_sum, stbl[gexp(k - 2)]);
            end else begin
                chk("burst_idle", bus0.resp_valid, 0);
            end
        end

        // Single request from requester 2: 0x12 + 0x34
        tick();
        bus0.req_valid = 4'b0100;
        bus0.req_a = {8'h00, 8'h12, 8'h00, 8'h00};
        bus0.req_b = {8'h00, 8'h34, 8'h00, 8'h00};
        #1;
        chk("one_gnt", bus0.req_ready, 4'b0100);
        chk("one_busy0", bus0.busy, 0);
        chk("one_ce", bus0.add_ce, 1);
        tick();
        bus0.req_valid = 4'b0000;
        #1;
        chk("one_gap_busy", bus0.busy, 1);
        chk("one_gap_resp", bus0.resp_valid, 0);
        chk("one_add_a", bus0.add_a, 8'h12);
        chk("one_add_b", bus0.add_b, 8'h34);
        tick();
        #1;
        chk("one_resp", bus0.resp_valid, 4'b0100);
        chk("one_sum", bus0.resp_sum, 8'h46);
        chk("one_busy", bus0.busy, 1);
        tick();
        #1;
        chk("one_after", bus0.resp_valid, 0);
        chk("one_idle", bus0.busy, 0);

        // Wrap-around: FF+01 then 80+80 from requester 0
        tick();
        bus0.req_valid = 4'b0001;
        bus0.req_a = {8'h00, 8'h00, 8'h00, 8'hFF};
        bus0.req_b = {8'h00, 8'h00, 8'h00, 8'h01};
        #1;
        chk("ovf_gnt0", bus0.req_ready, 4'b0001);
        tick();
        bus0.req_a = {8'h00, 8'h00, 8'h00, 8'h80};
        bus0.req_b = {8'h00, 8'h00, 8'h00, 8'h80};
        #1;
        chk("ovf_gnt1", bus0.req_ready, 4'b0001);
        tick();
        bus0.req_valid = 4'b0000;
        #1;
        chk("ovf_resp0", bus0.resp_valid, 4'b0001);
        chk("ovf_sum0", bus0.resp_sum, 8'h00);
        tick();
        #1;
        chk("ovf_resp1", bus0.resp_valid, 4'b0001);
        chk("ovf_sum1", bus0.resp_sum, 8'h00);
        tick();
        #1;
        chk("ovf_done", bus0.resp_valid, 0);
        chk("ovf_busy", bus0.busy, 0);

        // Hold for three cycles right after an accept (requester 1: 0x21+0x02)
        tick();
        bus0.req_valid = 4'b0010;
        bus0.req_a = {8'h00, 8'h00, 8'h21, 8'h00};
        bus0.req_b = {8'h00, 8'h00, 8'h02, 8'h00};
        #1;
        chk("hold_gnt", bus0.req_ready, 4'b0010);
        for (int h = 0; h < 3; h++) begin
            tick();
            bus0.hold = 1'b1;
            bus0.req_valid = 4'hF;
            #1;
            chk("hold_ready", bus0.req_ready, 0);
            chk("hold_ce", bus0.add_ce, 0);
            chk("hold_resp", bus0.resp_valid, 0);
            chk("hold_busy", bus0.busy, 1);
        end
        tick();
        bus0.hold = 1'b0;
        bus0.req_valid = 4'b0000;
        #1;
        chk("hold_c4_resp", bus0.resp_valid, 0);
        chk("hold_c4_ce", bus0.add_ce, 1);
        tick();
        #1;
        chk("hold_c5_resp", bus0.resp_valid, 4'b0010);
        chk("hold_c5_sum", bus0.resp_sum, 8'h23);
        tick();
        #1;
        chk("hold_c6_resp", bus0.resp_valid, 0);
        chk("hold_c6_busy", bus0.busy, 0);

        // Hold while the result sits at the tail (requester 3: 0x33+0x01)
        tick();
        bus0.req_valid = 4'b1000;
        bus0.req_a = {8'h33, 8'h00, 8'h00, 8'h00};
        bus0.req_b = {8'h01, 8'h00, 8'h00, 8'h00};
        #1;
        chk("tail_gnt", bus0.req_ready, 4'b1000);
        tick();
        bus0.req_valid = 4'b0000;
        #1;
        chk("tail_c1", bus0.resp_valid, 0);
        tick();
        bus0.hold = 1'b1;
        #1;
        chk("tail_held", bus0.resp_valid, 0);
        chk("tail_busy", bus0.busy, 1);
        tick();
        bus0.hold = 1'b0;
        #1;
        chk("tail_resp", bus0.resp_valid, 4'b1000);
        chk("tail_sum", bus0.resp_sum, 8'h34);
        tick();
        #1;
        chk("tail_once", bus0.resp_valid, 0);

        // Reset with two operations in flight
        tick();
        bus0.req_valid = 4'b0010;
        bus0.req_a = {8'h00, 8'h00, 8'h07, 8'h00};
        bus0.req_b = {8'h00, 8'h00, 8'h01, 8'h00};
        #1;
        chk("mrst_gnt1", bus0.req_ready, 4'b0010);
        tick();
        bus0.req_valid = 4'b0100;
        #1;
        chk("mrst_gnt2", bus0.req_ready, 4'b0100);
        tick();
        rst_n = 1'b0;
        bus0.req_valid = 4'hF;
        #1;
        chk("mrst_ready", bus0.req_ready, 0);
        chk("mrst_ce", bus0.add_ce, 0);
        tick();
        rst_n = 1'b1;
        bus0.req_valid = 4'b1001;
        bus0.req_a = {8'h44, 8'h00, 8'h00, 8'h11};
        bus0.req_b = {8'h01, 8'h00, 8'h00, 8'h01};
        #1;
        chk("mrst_busy", bus0.busy, 0);
        chk("mrst_resp", bus0.resp_valid, 0);
        chk("mrst_gnt0", bus0.req_ready, 4'b0001);
        tick();
        bus0.req_valid = 4'b0000;
        #1;
        chk("mrst_nopulse", bus0.resp_valid, 0);
        tick();
        #1;
        chk("mrst_resp0", bus0.resp_valid, 4'b0001);
        chk("mrst_sum0", bus0.resp_sum, 8'h12);
        tick();
        #1;
        chk("mrst_idle", bus0.busy, 0);

        // LATENCY=4: back-to-back requesters 1 and 3 (A=i, B=0x10)
        tick();
        bus1.req_valid = 4'b0010;
        bus1.req_a = {8'h03, 8'h00, 8'h01, 8'h00};
        bus1.req_b = {8'h10, 8'h00, 8'h10, 8'h00};
        #1;
        chk("l4_gnt1", bus1.req_ready, 4'b0010);
        tick();
        bus1.req_valid = 4'b1000;
        #1;
        chk("l4_gnt3", bus1.req_ready, 4'b1000);
        for (int j = 2; j < 5; j++) begin
            tick();
            bus1.req_valid = 4'b0000;
            #1;
            chk("l4_wait_resp", bus1.resp_valid, 0);
            chk("l4_wait_busy", bus1.busy, 1);
        end
        tick();
        #1;
        chk("l4_resp1", bus1.resp_valid, 4'b0010);
        chk("l4_sum1", bus1.resp_sum, 8'h11);
        tick();
        #1;
        chk("l4_resp3", bus1.resp_valid, 4'b1000);
        chk("l4_sum3", bus1.resp_sum, 8'h13);
        tick();
        #1;
        chk("l4_done", bus1.resp_valid, 0);
        chk("l4_idle", bus1.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sp_adder_arbiter.md
# sp_adder_arbiter

Shares one pipelined unsigned adder instance (the 8-bit single-precision adder wrapper) between `NUM_REQ` requesters. Each cycle it grants at most one requester, registers that requester's operands into the adder, and carries a requester tag down a shadow pipeline matched to the adder latency. The result is returned to the originating requester. It sits between the requester-side datapath and the adder wrapper and owns the adder's clock-enable.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand and sum width; must match the adder.
- `LATENCY`, 1: adder clock-enabled cycles from A/B capture to S valid; 1..8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous and active-low.
- `hold`  in  1  global stall; freezes the adder and the tag pipeline.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_a`  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  operand B; same packing as `req_a`.
- `req_ready`  out  NUM_REQ  one-hot grant; transfer when `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  NUM_REQ  one-hot, one-cycle pulse to the originating requester.
- `resp_sum`  out  WIDTH  sum (mod 2^WIDTH); meaningful only when `resp_valid` is nonzero.
- `busy`  out  1  any operation accepted and not yet returned.
- `add_ce`  out  1  adder clock-enable.
- `add_a`, `add_b`  out  WIDTH  registered adder operands.
- `add_s`  in  WIDTH  adder result.

## Operation
- Reset values (cycle after `rst_n`=0 sampled):
  - `add_a`, `add_b`, tag pipeline, `busy` = 0.
  - `req_ready` = 0 while `rst_n`=0.
  - `resp_valid` = 0.
  - `add_ce` = 0.
  - Priority pointer = `NUM_REQ-1`, so requester 0 has highest priority first.
- `add_ce` = `rst_n & ~hold`, combinational.
- Grant is combinational from `req_valid`, the pointer and `hold`.
  - If `hold`=1, `req_ready` = 0.
  - Otherwise the first valid requester scanning from pointer+1 (mod `NUM_REQ`) is granted.
  - `req_ready` must not depend on `req_a`/`req_b`.
- On each accepting edge:
  - Operands of the granted requester are loaded into `add_a`/`add_b`.
  - Tag stage 0 gets {valid=1, id}. On non-accept, non-hold edges, stage 0 gets valid=0.
  - Pointer updates to the granted id. Pointer is unchanged on cycles with no accept.
- Tag pipeline:
  - Depth `LATENCY+1` (operand register + adder stages).
  - Shifts only on edges with `hold`=0.
- Response: `resp_valid[i]` = tail.valid & tail.id==i & ~hold; `resp_sum` = `add_s`.
  - A held tail entry is presented exactly once, in the first cycle after `hold` drops.
- `busy` = OR of all tag valids.
- Wrap-around: addition is modulo 2^WIDTH. No carry is reported; 0xFF+0x01 returns 0x00.
- Mid-operation reset: all in-flight tags are discarded and no response is produced for them. The adder's internal state is ignored because its tags are invalid.
- There is no response back-pressure; requesters must always accept `resp_valid`.

## Timing
- Throughput: one operation per non-hold cycle.
- Latency, with no hold: accept in cycle c → `resp_valid` in cycle c+1+`LATENCY` (c+2 at default). Each hold cycle adds one cycle.
- Simultaneous requests: one grant per cycle. Losers keep `req_valid` high and their operands stable until granted.
- Accept and tail presentation happen in the same cycle independently; with no hold there are no bubbles.

## Configuration
- `SP_ADDER_ARB_RR_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority, lowest index wins. The pointer logic is removed and grant is independent of history; all other behaviour is identical.

## Test plan
- Single request, requester 2 only, A=0x12, B=0x34, default params:
  - `req_ready[2]`=1 the same cycle.
  - `resp_valid`=4'b0100 and `resp_sum`=0x46 exactly 2 cycles later.
  - `busy` is high during the gap.
- All four `req_valid` held high for 8 cycles, RR enabled:
  - Grants are 0,1,2,3,0,1,2,3.
  - Responses return in the same order, each at accept+2.
  - Without the macro, requester 0 is granted all 8 cycles.
- Overflow, A=0xFF, B=0x01, then A=0x80, B=0x80 → sums 0x00 and 0x00, no other flag.
- Accept in cycle c, `hold`=1 for cycles c+1..c+3:
  - `add_ce`=0 and `req_ready`=0 during the hold.
  - The response appears once, at c+5.
- Two operations in flight, `rst_n`=0 for one cycle:
  - No `resp_valid` pulse afterwards.
  - `busy`=0 the cycle after reset.
  - The pointer restarts so requester 0 wins.
- `LATENCY`=4, back-to-back accepts from requesters 1 and 3 (A=i, B=0x10):
  - Responses at accept+5 in order.
  - `resp_sum` = 0x11 and 0x13 respectively.
